// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - FNV-1a constants and scheduler state encoding
package hash_pkg;

  localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME  = 32'h01000193;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    DONE = 2'd2
  } hash_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after last winner
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   j;
  logic found;

  // first asserted request at last+1, last+2, ... wrapping; the last winner is checked last
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last) + i) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hash_sched.sv
// rtl/hash_sched.sv - round-robin FNV-1a hash scheduler; HASH_SCHED_PERF_EN adds perf_busy_cnt
module hash_sched
  import hash_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int d_size    = 32,
  parameter int hash_size = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*d_size-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [hash_size-1:0]       res_hash,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic                       busy
`ifdef HASH_SCHED_PERF_EN
  , output logic [31:0]              perf_busy_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int NB = d_size / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  hash_sched_state_e    state;
  logic [d_size-1:0]    data_q;
  logic [IW-1:0]        id_q;
  logic [IW-1:0]        last_q;
  logic [hash_size-1:0] acc;
  logic [BW-1:0]        bcnt;

  logic [N_REQ-1:0]     arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 accept;
  logic [7:0]           cur_byte;
  logic [hash_size-1:0] mix;
  logic [hash_size-1:0] prod;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;
  assign accept    = |req_ready;
  assign res_valid = (state == DONE);
  assign res_hash  = acc;
  assign res_id    = id_q;
  assign busy      = (state != IDLE);

  // one FNV-1a step on the current byte, least significant byte first
  assign cur_byte = data_q[bcnt*8 +: 8];
  assign mix      = acc ^ hash_size'(cur_byte);
  assign prod     = mix * hash_size'(FNV_PRIME);

  // IDLE accepts a word, HASH consumes one byte per cycle, DONE holds the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      id_q   <= '0;
      last_q <= IW'(N_REQ - 1);
      acc    <= '0;
      bcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= req_data[int'(arb_idx)*d_size +: d_size];
            id_q   <= arb_idx;
            last_q <= arb_idx;
            acc    <= hash_size'(FNV_OFFSET);
            bcnt   <= '0;
            state  <= HASH;
          end
        end
        HASH: begin
          acc  <= prod;
          bcnt <= bcnt + 1'b1;
          if (bcnt == BW'(NB - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HASH_SCHED_PERF_EN
  // saturating count of cycles spent outside IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cnt <= '0;
    end else if (busy && perf_busy_cnt != 32'hFFFF_FFFF) begin
      perf_busy_cnt <= perf_busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_sched.sv
// tb/tb_hash_sched.sv - scoreboard bench for hash_sched
module tb_hash_sched;

  localparam int N  = 4;
  localparam int D  = 32;
  localparam int NB = D / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*D-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_hash;
  logic [1:0]       res_id;
  logic             busy;
`ifdef HASH_SCHED_PERF_EN
  logic [31:0]      perf_busy_cnt;
`endif

  hash_sched #(.N_REQ(N), .d_size(D), .hash_size(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hash  (res_hash),
    .res_id    (res_id),
    .busy      (busy)
`ifdef HASH_SCHED_PERF_EN
    , .perf_busy_cnt (perf_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] hash;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_last = N - 1;
  int   last_acc = -1;
  bit   stream = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fnv(logic [31:0] d);
    logic [31:0] h;
    h = 32'h811C9DC5;
    for (int k = 0; k < NB; k++) begin
      h = (h ^ {24'h0, d[k*8 +: 8]}) * 32'h01000193;
    end
    return h;
  endfunction

  function automatic int model_grant(logic [N-1:0] v, int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: arbitration model, scoreboard push on accept, pop on result handshake
  initial begin
    logic        pv, pr;
    logic [31:0] ph;
    logic [1:0]  pid;
    int          g;
    logic [N-1:0] exp_ready;
    exp_t        e;
    pv = 0; pr = 0; ph = '0; pid = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        pr = 0;
      end else begin
        check("onehot0", ($countones(req_ready) <= 1), 1);
        if (busy) begin
          check("ready_while_busy", req_ready, 0);
        end else begin
          g = model_grant(req_valid, m_last);
          exp_ready = '0;
          if (g >= 0) exp_ready[g] = 1'b1;
          check("grant", req_ready, exp_ready);
          if (g >= 0) begin
            e.id = g;
            e.hash = fnv(req_data[g*D +: D]);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            if (stream && last_acc >= 0) check("throughput", cyc - last_acc, NB + 2);
            last_acc = cyc;
            m_last = g;
          end
        end
        if (res_valid && !pv) begin
          if (exp_q.size() == 0) check("spurious_res_valid", 1, 0);
          else check("latency", cyc - exp_q[0].acc_cyc, NB + 1);
        end
        if (pv && !pr) begin
          check("hold_valid", res_valid, 1);
          check("hold_hash", res_hash, ph);
          check("hold_id", res_id, pid);
        end
        if (res_valid && res_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res_hash", res_hash, e.hash);
          check("res_id", res_id, e.id);
        end
        pv = res_valid; pr = res_ready; ph = res_hash; pid = res_id;
      end
    end
  end

  task automatic send(int idx, logic [31:0] d);
    bit got;
    got = 0;
    req_data[idx*D +: D] = d;
    req_valid[idx] = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1;
    end
    if (!got) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_hash", res_hash, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);
`ifdef HASH_SCHED_PERF_EN
    check("rst_perf", perf_busy_cnt, 0);
`endif
    @(posedge clk); #1;

    // single jobs across requesters and data patterns
    send(0, 32'h0000_0061);
    drain();
`ifdef HASH_SCHED_PERF_EN
    check("perf_one_job", perf_busy_cnt, 5);
`endif
    send(1, 32'h0000_0000);
    drain();
    send(2, 32'hFFFF_FFFF);
    drain();
    send(3, $urandom);
    drain();

    // all requesters valid, results taken immediately
    for (int i = 0; i < N; i++) req_data[i*D +: D] = $urandom;
    stream = 1;
    last_acc = -1;
    req_valid = '1;
    n = 0;
    for (int c = 0; c < 300 && n < 8; c++) begin
      @(negedge clk);
      seen = 0;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          seen = 1;
          n++;
          @(posedge clk); #1;
          req_data[i*D +: D] = $urandom;
        end
      end
      if (!seen) begin
        @(posedge clk); #1;
      end
    end
    if (n < 8) check("stream_timeout", 0, 1);
    req_valid = '0;
    stream = 0;
    drain();

    // back-pressure in DONE
    res_ready = 1'b0;
    req_data[0 +: D] = $urandom;
    req_data[2*D +: D] = $urandom;
    req_data[1*D +: D] = $urandom;
    req_valid = 4'b0101;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    if (!seen) check("bp_timeout", 0, 1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 4) req_valid = 4'b0011;
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_no_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("accept_after_hs", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // reset in the middle of HASH
    send(2, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    m_last = N - 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_hash", res_hash, 0);
    check("mid_rst_res_id", res_id, 0);
    check("mid_rst_req_ready", req_ready, 0);
    repeat (8) @(negedge clk);
    check("mid_rst_no_result", res_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) req_data[i*D +: D] = $urandom;
    req_valid = '1;
    @(negedge clk);
    check("restart_req0", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
